encoder_ctrl: RTL
=================

# encoder_ctrl

Sequencing controller for the matrix-encoder datapath. It streams 64 input lines of 25 bits through the datapath. For each line it:
- clears, then loads the line register;
- runs a configurable number of column-parity permutation passes;
- presents the result for writing.

It drives every datapath enable, uses the datapath's 6-bit line counter for progress, and exposes ready/valid handshakes toward the line source and the result sink.

## Interface
- `ROUNDS`, default 1: permutation passes per line, legal range 1..15.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: begin a 64-line job. Sampled only in IDLE.
- `in_valid`  in  1: source has a line on the datapath's `line_in`.
- `in_ready`  out  1: controller accepts a line this cycle.
- `out_valid`  out  1: datapath `write_value` holds a finished line.
- `out_ready`  in  1: sink takes the line this cycle.
- `counter_co`  in  1: datapath line-counter carry (value 63).
- `cnt_value`  in  6: datapath line-counter value.
- `read_en`, `mux_en`, `reg_en`, `reg_rst`, `cnt_64_en`, `permute_en`, `write_en`  out  1 each: datapath controls.
- `busy`  out  1: a job is in progress.
- `done`  out  1: one-cycle pulse when the job completes.

## Operation
- FSM states: IDLE, CLEAR, LOAD, PERM, WRITE, DONE.
- **IDLE**
  - `busy`=0.
  - `start`=1 → CLEAR.
- **CLEAR**
  - `reg_rst`=1 for one cycle.
  - → LOAD.
- **LOAD**
  - `in_ready`=`read_en`=1, `mux_en`=0.
  - `reg_en`=`in_valid`, combinational.
  - `in_valid`=1 → PERM, with the round count cleared.
  - `in_valid`=0 → stay in LOAD.
- **PERM**
  - `mux_en`=`permute_en`=`reg_en`=1.
  - The round count increments every cycle.
  - After `ROUNDS` cycles → WRITE.
- **WRITE**
  - `out_valid`=`write_en`=1.
  - `reg_en`=0, so the line register holds.
  - `out_ready`=1 → `cnt_64_en`=1 (combinational, one cycle). Then:
    - if `cnt_value`==63 (`counter_co`=1) → DONE;
    - else → LOAD.
  - `out_ready`=0 → stay in WRITE; the output is held stable.
- **DONE**
  - `done`=1 for one cycle.
  - → IDLE.
- The line counter wraps 63→0 on the 64th accepted write, so it reads 0 again at DONE.
- All outputs not listed for a state are 0. `busy`=1 in every state except IDLE.
- `start` while busy is ignored. There is no queuing.
- The controller never asserts `in_ready` and `out_valid` in the same cycle.
- The round count is 4 bits wide. `ROUNDS` outside 1..15 is a compile-time error via an elaboration-time check.

## Timing
- **Reset:** `rst` low forces state IDLE, round count 0 and every output 0, asynchronously. Release is synchronous to the next `clk` edge.
- **Reset mid-job:** the job is abandoned with no `done` pulse. The datapath counter shares `rst`, so it also returns to 0.
- **Start to first `in_ready`:** `start` sampled high at edge k gives CLEAR in cycle k+1 and LOAD (`in_ready`=1) in cycle k+2.
- **Per-line minimum (no stalls):** 1 LOAD + `ROUNDS` PERM + 1 WRITE cycles.
- **Whole job, no stalls:** `start` edge to `done` = 2 + 64·(`ROUNDS`+2) cycles. For `ROUNDS`=1 that is 194.
- **Stalls:** each cycle of `in_valid`=0 in LOAD, or `out_ready`=0 in WRITE, adds exactly one cycle.
- **`cnt_64_en`:** asserted only in the cycle where `out_valid`&&`out_ready`.
- **`done`:** asserted in the cycle after the 64th write handshake.

## Configuration
- Macro: `ENC_CTRL_ABORT_EN`.
- **Defined:**
  - Adds input port `abort` (1 bit).
  - `abort`=1 in any state other than IDLE → next state IDLE, with no `done` pulse.
  - In the abort cycle `reg_rst`=1 and `cnt_64_en`=0.
  - The datapath counter is not rewound. The next `start` waits in CLEAR until `cnt_value`==0, pulsing `cnt_64_en` each cycle to wrap it.
  - `abort` has priority over every handshake in the same cycle.
- **Undefined:** no `abort` port. Jobs always run to completion or reset.

## Structure
- Package `enc_pkg`:
  - state enum `enc_state_t`;
  - constants `LINE_W`=25, `LINES`=64, `CNT_W`=6, `ROUND_W`=4.
- One sub-module, `enc_round_counter`: a 4-bit counter with clear, enable and a terminal flag at `ROUNDS`-1, used in PERM.
- FSM and output decode live in `encoder_ctrl`.

## Test plan
- **Reset behaviour:** drive `rst`=0 mid-PERM → all outputs 0 immediately, state IDLE. After release with `start`=0, `busy` stays 0.
- **Full job, no stalls:** `ROUNDS`=1, `in_valid`=`out_ready`=1 always → exactly 64 `cnt_64_en` pulses, and `done` exactly 194 cycles after the `start` edge.
- **Stalls:** `ROUNDS`=3; hold `in_valid`=0 for 5 cycles on line 10 and `out_ready`=0 for 7 cycles on line 20.
  - `done` arrives at 2+64·5+12 = 334 cycles.
  - `write_value` is stable throughout the stall.
- **Start while busy:** pulse `start` at line 30 → no restart. One `done` only, and `cnt_value` wraps to 0.
- **Abort (`ENC_CTRL_ABORT_EN`):** assert `abort` at `cnt_value`=17 in WRITE with `out_ready`=1.
  - → IDLE, no `cnt_64_en`, no `done`.
  - A new `start` holds in CLEAR for 47 cycles before LOAD.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the matrix-encoder sequencing controller.
// The enc_decode helper maps a state onto the set of datapath controls it drives.
package enc_pkg;

  localparam int unsigned LINE_W  = 25;
  localparam int unsigned LINES   = 64;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned ROUND_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    PERM,
    WRITE,
    DONE
  } enc_state_t;

  typedef struct packed {
    logic busy;
    logic in_ready;
    logic read_en;
    logic mux_en;
    logic permute_en;
    logic perm_reg_en;
    logic reg_rst;
    logic out_valid;
    logic write_en;
    logic done;
  } enc_ctrl_t;

  function automatic enc_ctrl_t enc_decode(input enc_state_t s);
    enc_ctrl_t c;
    c      = '0;
    c.busy = (s != IDLE);
    case (s)
      CLEAR: c.reg_rst = 1'b1;
      LOAD: begin
        c.in_ready = 1'b1;
        c.read_en  = 1'b1;
      end
      PERM: begin
        c.mux_en      = 1'b1;
        c.permute_en  = 1'b1;
        c.perm_reg_en = 1'b1;
      end
      WRITE: begin
        c.out_valid = 1'b1;
        c.write_en  = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/enc_round_counter.sv
// Permutation-pass counter: clears outside PERM, counts each PERM cycle and
// flags the final pass (count == ROUNDS-1).
module enc_round_counter
  import enc_pkg::*;
#(
  parameter int unsigned ROUNDS = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
    $error("enc_round_counter: ROUNDS must be within 1..15");
  end

  logic [ROUND_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + ROUND_W'(1);
    end
  end

  assign o_term = i_en && (r_count == ROUND_W'(ROUNDS - 1));

endmodule

// File: rtl/encoder_ctrl.sv
// Sequencing controller streaming 64 lines through the matrix-encoder datapath.
// Optional feature macro: ENC_CTRL_ABORT_EN (adds the abort input).
module encoder_ctrl
  import enc_pkg::*;
#(
  parameter int unsigned ROUNDS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             counter_co,
  input  logic [CNT_W-1:0] cnt_value,
  output logic             read_en,
  output logic             mux_en,
  output logic             reg_en,
  output logic             reg_rst,
  output logic             cnt_64_en,
  output logic             permute_en,
  output logic             write_en,
  output logic             busy,
  output logic             done
`ifdef ENC_CTRL_ABORT_EN
  ,
  input  logic             abort
`endif
);

  enc_state_t r_state;
  enc_state_t w_next;
  enc_ctrl_t  r_ctrl;
  logic       w_round_term;
  logic       w_last;
  logic       w_abort;
  logic       w_wr_hs;

  enc_round_counter #(
    .ROUNDS(ROUNDS)
  ) u_round (
    .i_clk  (clk),
    .i_rst_n(rst),
    .i_clr  (r_state != PERM),
    .i_en   (r_state == PERM),
    .o_term (w_round_term)
  );

  assign w_last = counter_co && (cnt_value == CNT_W'(LINES - 1));

`ifdef ENC_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = CLEAR;
`ifdef ENC_CTRL_ABORT_EN
      // Counter is wound forward to 0; leaving on 63 lets the wrap pulse land on the exit edge.
      CLEAR: if ((cnt_value == '0) || w_last) w_next = LOAD;
`else
      CLEAR: w_next = LOAD;
`endif
      LOAD:  if (in_valid) w_next = PERM;
      PERM:  if (w_round_term) w_next = WRITE;
      WRITE: if (out_ready) w_next = w_last ? DONE : LOAD;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort) w_next = IDLE;
  end

  // Outputs are registered by decoding the next state alongside the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= enc_decode(w_next);
    end
  end

  assign busy       = r_ctrl.busy;
  assign in_ready   = r_ctrl.in_ready;
  assign read_en    = r_ctrl.read_en;
  assign mux_en     = r_ctrl.mux_en;
  assign permute_en = r_ctrl.permute_en;
  assign out_valid  = r_ctrl.out_valid;
  assign write_en   = r_ctrl.write_en;
  assign done       = r_ctrl.done;
  assign reg_en     = r_ctrl.perm_reg_en | (r_ctrl.in_ready & in_valid);
  assign reg_rst    = r_ctrl.reg_rst | w_abort;
  assign w_wr_hs    = r_ctrl.out_valid & out_ready & ~w_abort;

`ifdef ENC_CTRL_ABORT_EN
  assign cnt_64_en = w_wr_hs | ((r_state == CLEAR) && (cnt_value != '0) && !w_abort);
`else
  assign cnt_64_en = w_wr_hs;
`endif

endmodule
